harz_req_initiator: RTL and testbench
=====================================

Name: harz_req_initiator

Overview:
- Initiator (client) end of the harzbus request/busy handshake; the MMU is the host end.
- Accepts memory/IO commands from an internal sequencer through a valid/ready port and buffers them in a small FIFO.
- Issues each command as one harzbus transaction and returns a one-cycle response pulse carrying read data.
- Sits between command-producing logic (player/control FSMs) and the MMU's bus_Harz port.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 1024, busy-wait limit in i_CLK cycles; used only with the optional feature.

Ports:
- i_CLK  in  1  system clock; single clock domain.
- i_RST  in  1  reset; synchronous, active-high.
- i_CMD_VALID  in  1  command offered.
- o_CMD_READY  out  1  FIFO not full.
- i_CMD_KIND  in  2  command kind: 00 mem read, 01 mem write, 10 IO read, 11 IO write.
- i_CMD_ADDR  in  16  address.
- i_CMD_WDATA  in  8  write data.
- o_RSP_VALID  out  1  one-cycle completion pulse.
- o_RSP_RDATA  out  8  read data; 0x00 for writes.
- o_RSP_TIMEOUT  out  1  completion was a timeout; qualified by o_RSP_VALID.
- o_IDLE  out  1  FIFO empty and FSM in ST_IDLE.
- o_HARZ_REQUEST  out  harz_req_t  drives bus_Harz.request.
- o_HARZ_ADDRESS  out  16  drives bus_Harz.address.
- o_HARZ_WRITE_DATA  out  8  drives bus_Harz.write_data.
- i_HARZ_BUSY  in  1  from bus_Harz.busy.
- i_HARZ_READ_DATA  in  8  from bus_Harz.read_data.

Behaviour:
- Reset values:
  - o_HARZ_REQUEST = HARZ80_NONE; o_HARZ_ADDRESS = 0; o_HARZ_WRITE_DATA = 0.
  - o_RSP_VALID = 0; o_RSP_RDATA = 0; o_RSP_TIMEOUT = 0; o_IDLE = 1.
  - FIFO flushed; FSM in ST_IDLE.
- Kind mapping to harz_req_t:
  - 00 -> HARZ80_MEM_READ_1; 01 -> HARZ80_MEM_WRITE_1.
  - 10 -> HARZ80_IO_READ; 11 -> HARZ80_IO_WRITE.
- FIFO push: on i_CMD_VALID & o_CMD_READY.
- o_CMD_READY = !full. When full, a push is refused even if a pop occurs in the same cycle.
- All harzbus outputs are registered. Every state below is held until the exit condition named in it occurs.
- FSM:
  - ST_IDLE: if FIFO not empty -> pop the head entry, load o_HARZ_ADDRESS, o_HARZ_WRITE_DATA and o_HARZ_REQUEST, go to ST_REQ. A command pushed into an empty FIFO at edge k drives o_HARZ_REQUEST after edge k+1.
  - ST_REQ: hold the request until i_HARZ_BUSY=1 is sampled. Then set o_HARZ_REQUEST=HARZ80_NONE and go to ST_BUSY. A low busy on entry is never treated as completion.
  - ST_BUSY: when i_HARZ_BUSY=0 is sampled:
    - capture i_HARZ_READ_DATA for reads, 0x00 for writes;
    - go to ST_DONE.
  - ST_DONE: o_RSP_VALID=1 for exactly this one cycle, then go to ST_GAP.
  - ST_GAP: one cycle with request NONE, then go to ST_IDLE. This covers the host's finish cycle.
- Request is never non-NONE for two back-to-back transactions without an intervening NONE cycle.
- Minimum transaction turnaround: 5 i_CLK cycles (ST_IDLE through ST_GAP) plus host busy time.
- o_IDLE = FIFO empty & ST_IDLE.
- Reset mid-transaction:
  - request returns to NONE on the next edge;
  - no response pulse is emitted;
  - queued commands are discarded.

Optional Feature:
- Macro: HARZ_REQ_TIMEOUT_EN.
- When defined:
  - a counter clears on entering ST_REQ and increments every cycle in ST_REQ and ST_BUSY;
  - at count == TIMEOUT_CYCLES-1: request forced to NONE; response pulsed with o_RSP_TIMEOUT=1 and o_RSP_RDATA=0xFF; FSM goes to ST_RECOVER;
  - ST_RECOVER waits for i_HARZ_BUSY=0, then goes to ST_GAP with no second response.
- When not defined:
  - no counter and no ST_RECOVER state;
  - o_RSP_TIMEOUT tied to 0;
  - the FSM waits indefinitely.

Test Plan:
1. Mem write: push kind 01, addr 0x8000, data 0x5A. Model host raises busy 1 cycle after request and holds it 3 cycles. Expect: request MEM_WRITE_1 with addr 0x8000 / data 0x5A; request NONE after busy is seen; one response pulse with rdata 0x00.
2. IO read: push kind 10, addr 0x00A2. Host returns read_data 0x3C as busy falls. Expect: request IO_READ; o_RSP_RDATA=0x3C; o_RSP_VALID high exactly 1 cycle.
3. Backpressure: hold the host busy and push 6 commands back-to-back. Expect: o_CMD_READY drops after 4 accepted (FIFO_DEPTH=4, one already popped gives 5 accepted). All accepted commands complete in order, with a NONE cycle between requests.
4. Reset mid-operation: assert i_RST while in ST_BUSY with 2 queued. Expect: request NONE next edge; no response; o_IDLE=1; the queued commands are never issued.
5. Timeout (HARZ_REQ_TIMEOUT_EN, TIMEOUT_CYCLES=16): host never raises busy. Expect a response at cycle 16 after request with o_RSP_TIMEOUT=1 and rdata 0xFF, then the next command issues normally.
6. Back-to-back mixed sequence: mem read 0x0000, IO write 0x7C/0x11, mem read 0xFFFF. Expect 3 responses in order, with rdata from the host model for the reads and 0x00 for the write.

Source files
------------

// File: rtl/harz_req_initiator.sv
// -----------------------------------------------------------------------------
// harz_req_initiator
//
// Initiator (client) end of the harzbus request/busy handshake. Commands from
// an internal sequencer arrive on a valid/ready port and are buffered in a
// small FIFO. Each command is issued to the MMU host as one harzbus transaction.
// Its completion is returned as a one-cycle response pulse that carries the
// read data.
//
// Optional feature, selected with the macro HARZ_REQ_TIMEOUT_EN:
//   A busy-wait watchdog. A transaction that stays in ST_REQ/ST_BUSY for
//   TIMEOUT_CYCLES cycles is abandoned. Its response is flagged with
//   o_RSP_TIMEOUT and read data 0xFF.
//   Without the macro the FSM waits indefinitely and o_RSP_TIMEOUT is 0.
//
// Parameters:
//   FIFO_DEPTH      command FIFO entries (power of 2, >= 2)
//   TIMEOUT_CYCLES  busy-wait limit in i_CLK cycles (watchdog build only)
//
// Ports:
//   i_CLK, i_RST        clock; synchronous active-high reset
//   i_CMD_VALID         command offered
//   o_CMD_READY         FIFO not full
//   i_CMD_KIND          00 mem read, 01 mem write, 10 IO read, 11 IO write
//   i_CMD_ADDR          16-bit address
//   i_CMD_WDATA         8-bit write data
//   o_RSP_VALID         one-cycle completion pulse
//   o_RSP_RDATA         read data (0x00 for writes)
//   o_RSP_TIMEOUT       completion was a timeout; qualified by o_RSP_VALID
//   o_IDLE              FIFO empty and FSM in ST_IDLE
//   o_HARZ_REQUEST      drives bus_Harz.request      (registered)
//   o_HARZ_ADDRESS      drives bus_Harz.address      (registered)
//   o_HARZ_WRITE_DATA   drives bus_Harz.write_data   (registered)
//   i_HARZ_BUSY         from bus_Harz.busy
//   i_HARZ_READ_DATA    from bus_Harz.read_data
// -----------------------------------------------------------------------------

package harz_pkg;

  typedef enum logic [2:0] {
    HARZ80_NONE        = 3'd0,
    HARZ80_MEM_READ_1  = 3'd1,
    HARZ80_MEM_WRITE_1 = 3'd2,
    HARZ80_IO_READ     = 3'd3,
    HARZ80_IO_WRITE    = 3'd4
  } harz_req_t;

endpackage

module harz_req_initiator
  import harz_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  input  logic [1:0]  i_CMD_KIND,
  input  logic [15:0] i_CMD_ADDR,
  input  logic [7:0]  i_CMD_WDATA,
  output logic        o_RSP_VALID,
  output logic [7:0]  o_RSP_RDATA,
  output logic        o_RSP_TIMEOUT,
  output logic        o_IDLE,
  output harz_req_t   o_HARZ_REQUEST,
  output logic [15:0] o_HARZ_ADDRESS,
  output logic [7:0]  o_HARZ_WRITE_DATA,
  input  logic        i_HARZ_BUSY,
  input  logic [7:0]  i_HARZ_READ_DATA
);

  localparam int unsigned      AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1);
  localparam logic [AW:0]      FILL_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]      FILL_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_BUSY,
    ST_DONE,
    ST_GAP
`ifdef HARZ_REQ_TIMEOUT_EN
    , ST_RECOVER
`endif
  } state_t;

  function automatic harz_req_t kind_to_req(input logic [1:0] kind);
    harz_req_t req;
    case (kind)
      2'b00:   req = HARZ80_MEM_READ_1;
      2'b01:   req = HARZ80_MEM_WRITE_1;
      2'b10:   req = HARZ80_IO_READ;
      default: req = HARZ80_IO_WRITE;
    endcase
    return req;
  endfunction

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t          fifo_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  cmd_t          head;

  assign fifo_full  = (fill_q == FILL_FULL);
  assign fifo_empty = (fill_q == '0);
  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  assign push       = i_CMD_VALID & ~fifo_full;
  assign head       = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase
  end

  // NOTE: the storage array is deliberately not reset; the pointers and fill
  // count alone decide which entries hold live commands.
  always_ff @(posedge i_CLK) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{kind: i_CMD_KIND, addr: i_CMD_ADDR, wdata: i_CMD_WDATA};
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM and registered bus outputs
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  harz_req_t   req_q, req_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        is_write_q, is_write_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef HARZ_REQ_TIMEOUT_EN
  localparam int unsigned   TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          rsp_timeout_q, rsp_timeout_d;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_write_d  = is_write_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    pop         = 1'b0;
`ifdef HARZ_REQ_TIMEOUT_EN
    rsp_timeout_d = 1'b0;
    tmo_cnt_d     = tmo_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          addr_d     = head.addr;
          wdata_d    = head.wdata;
          req_d      = kind_to_req(head.kind);
          is_write_d = head.kind[0];
          state_d    = ST_REQ;
        end
      end
      // Busy may still be low from the previous transaction's tail; only a
      // high busy means the host has taken the request.
      ST_REQ: begin
        if (i_HARZ_BUSY) begin
          req_d   = HARZ80_NONE;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!i_HARZ_BUSY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = is_write_q ? 8'h00 : i_HARZ_READ_DATA;
          state_d     = ST_DONE;
        end
      end
      // o_RSP_VALID is high for exactly the cycle spent here.
      ST_DONE: state_d = ST_GAP;
      // Guaranteed NONE cycle that covers the host's finish cycle.
      ST_GAP:  state_d = ST_IDLE;
`ifdef HARZ_REQ_TIMEOUT_EN
      // The host may still be busy on an abandoned transaction; wait it out
      // silently before the next command.
      ST_RECOVER: begin
        if (!i_HARZ_BUSY) state_d = ST_GAP;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef HARZ_REQ_TIMEOUT_EN
    // The counter sits at zero in every other state, so it starts from zero
    // on entry to ST_REQ. Expiry overrides the normal transitions above.
    if (state_q == ST_REQ || state_q == ST_BUSY) begin
      tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      if (tmo_cnt_q == TMO_LAST) begin
        req_d         = HARZ80_NONE;
        rsp_valid_d   = 1'b1;
        rsp_timeout_d = 1'b1;
        rsp_rdata_d   = 8'hFF;
        state_d       = ST_RECOVER;
      end
    end else begin
      tmo_cnt_d = '0;
    end
`endif
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q     <= ST_IDLE;
      req_q       <= HARZ80_NONE;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_write_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
`ifdef HARZ_REQ_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_write_q  <= is_write_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
`ifdef HARZ_REQ_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      rsp_timeout_q <= rsp_timeout_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_CMD_READY       = ~fifo_full;
  assign o_RSP_VALID       = rsp_valid_q;
  assign o_RSP_RDATA       = rsp_rdata_q;
  assign o_IDLE            = fifo_empty && (state_q == ST_IDLE);
  assign o_HARZ_REQUEST    = req_q;
  assign o_HARZ_ADDRESS    = addr_q;
  assign o_HARZ_WRITE_DATA = wdata_q;

`ifdef HARZ_REQ_TIMEOUT_EN
  assign o_RSP_TIMEOUT = rsp_timeout_q;
`else
  assign o_RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_harz_req_initiator.sv
// -----------------------------------------------------------------------------
// tb_harz_req_initiator
//
// Directed bench for harz_req_initiator. A host model answers each request
// with a configurable busy window. Read data is a function of the address.
// Expected issues and responses are queued when a command is driven and
// checked when the DUT produces them. The timeout scenario is compiled only
// when HARZ_REQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_harz_req_initiator;
  import harz_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_kind;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic        idle;
  harz_req_t   harz_req;
  logic [15:0] harz_addr;
  logic [7:0]  harz_wdata;
  logic        harz_busy;
  logic [7:0]  harz_rdata;

  always #5 clk = ~clk;

  harz_req_initiator #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_CLK             (clk),
    .i_RST             (rst),
    .i_CMD_VALID       (cmd_valid),
    .o_CMD_READY       (cmd_ready),
    .i_CMD_KIND        (cmd_kind),
    .i_CMD_ADDR        (cmd_addr),
    .i_CMD_WDATA       (cmd_wdata),
    .o_RSP_VALID       (rsp_valid),
    .o_RSP_RDATA       (rsp_rdata),
    .o_RSP_TIMEOUT     (rsp_timeout),
    .o_IDLE            (idle),
    .o_HARZ_REQUEST    (harz_req),
    .o_HARZ_ADDRESS    (harz_addr),
    .o_HARZ_WRITE_DATA (harz_wdata),
    .i_HARZ_BUSY       (harz_busy),
    .i_HARZ_READ_DATA  (harz_rdata)
  );

  typedef struct {
    harz_req_t   req;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        is_write;
  } exp_iss_t;

  typedef struct {
    logic [7:0] rdata;
    logic       tmo;
  } exp_rsp_t;

  exp_iss_t iss_q[$];
  exp_rsp_t rsp_q[$];

  int        checks       = 0;
  int        errors       = 0;
  int        cyc          = 0;
  int        issue_seen   = 0;
  int        rsp_seen     = 0;
  int        last_req_cyc = 0;
  int        last_rsp_cyc = 0;
  int        busy_len     = 3;
  logic      host_silent  = 1'b0;
  harz_req_t prev_req;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] host_rdata(input logic [15:0] addr);
    return addr[7:0] + addr[15:8] + 8'h9A;
  endfunction

  function automatic harz_req_t exp_req(input logic [1:0] kind);
    case (kind)
      2'b00:   return HARZ80_MEM_READ_1;
      2'b01:   return HARZ80_MEM_WRITE_1;
      2'b10:   return HARZ80_IO_READ;
      default: return HARZ80_IO_WRITE;
    endcase
  endfunction

  // Called one delta after a rising edge; offers the command for one cycle.
  task automatic push(input logic [1:0] kind, input logic [15:0] addr,
                      input logic [7:0] wdata, input logic exp_ready,
                      input logic exp_tmo);
    exp_iss_t ei;
    exp_rsp_t er;
    cmd_valid = 1'b1;
    cmd_kind  = kind;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    if (exp_ready) begin
      ei.req      = exp_req(kind);
      ei.addr     = addr;
      ei.wdata    = wdata;
      ei.is_write = kind[0];
      iss_q.push_back(ei);
      er.tmo   = exp_tmo;
      er.rdata = exp_tmo ? 8'hFF : (kind[0] ? 8'h00 : host_rdata(addr));
      rsp_q.push_back(er);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((rsp_q.size() != 0 || idle !== 1'b1) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_rsp_queue", 32'(rsp_q.size()), 32'd0);
    check("drain_iss_queue", 32'(iss_q.size()), 32'd0);
    check("idle_after_drain", 32'(idle), 32'd1);
  endtask

  // Host model: raises busy one cycle after it sees a request and holds it
  // for busy_len cycles. It returns read data as busy falls.
  initial begin : host_model
    exp_iss_t ei;
    int       len;
    harz_busy  = 1'b0;
    harz_rdata = 8'h00;
    prev_req   = HARZ80_NONE;
    forever begin
      @(posedge clk); #1;
      if (!rst && harz_req != HARZ80_NONE) begin
        issue_seen++;
        last_req_cyc = cyc;
        check("gap_before_req", 32'(prev_req), 32'(HARZ80_NONE));
        check("issue_expected", 32'(iss_q.size() != 0), 32'd1);
        if (iss_q.size() != 0) begin
          ei = iss_q.pop_front();
          check("req_kind", 32'(harz_req), 32'(ei.req));
          check("req_addr", 32'(harz_addr), 32'(ei.addr));
          if (ei.is_write) check("req_wdata", 32'(harz_wdata), 32'(ei.wdata));
        end else begin
          ei.req      = harz_req;
          ei.addr     = harz_addr;
          ei.wdata    = harz_wdata;
          ei.is_write = 1'b0;
        end
        len = busy_len;
        if (!host_silent) begin
          @(posedge clk); #1;
          check("req_held_before_busy", 32'(harz_req), 32'(ei.req));
          harz_busy = 1'b1;
          @(posedge clk); #1;
          check("req_none_after_busy", 32'(harz_req), 32'(HARZ80_NONE));
          for (int i = 1; i < len && !rst; i++) begin
            @(posedge clk); #1;
          end
          harz_busy  = 1'b0;
          harz_rdata = host_rdata(ei.addr);
        end else begin
          for (int i = 0; i < 256 && harz_req != HARZ80_NONE; i++) begin
            @(posedge clk); #1;
          end
        end
      end
      prev_req = harz_req;
    end
  end

  initial begin : rsp_monitor
    exp_rsp_t er;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        rsp_seen++;
        last_rsp_cyc = cyc;
        check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          er = rsp_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(er.rdata));
          check("rsp_timeout", 32'(rsp_timeout), 32'(er.tmo));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int iss0;
    int rsp0;
    int n;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind  = 2'b00;
    cmd_addr  = 16'h0000;
    cmd_wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_request", 32'(harz_req), 32'(HARZ80_NONE));
    check("rst_address", 32'(harz_addr), 32'd0);
    check("rst_wdata", 32'(harz_wdata), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: memory write
    rsp0 = rsp_seen;
    push(2'b01, 16'h8000, 8'h5A, 1'b1, 1'b0);
    wait_done(200);
    check("t1_rsp_count", 32'(rsp_seen - rsp0), 32'd1);

    // 2: IO read, host returns 0x3C for 0x00A2
    rsp0 = rsp_seen;
    push(2'b10, 16'h00A2, 8'h00, 1'b1, 1'b0);
    wait_done(200);
    check("t2_rsp_count", 32'(rsp_seen - rsp0), 32'd1);

    // 3: backpressure with a long busy window; five accepted, sixth refused
    rsp0     = rsp_seen;
    busy_len = 30;
    for (int i = 0; i < 6; i++) begin
      push(2'(i), 16'h1000 + 16'(i), 8'h20 + 8'(i), (i < 5), 1'b0);
    end
    check("t3_ready_held_low", 32'(cmd_ready), 32'd0);
    busy_len = 3;
    wait_done(600);
    check("t3_rsp_count", 32'(rsp_seen - rsp0), 32'd5);

    // 4: reset while in ST_BUSY with two commands queued
    rsp0     = rsp_seen;
    busy_len = 20;
    push(2'b00, 16'h4000, 8'h00, 1'b1, 1'b0);
    push(2'b01, 16'h4001, 8'hA1, 1'b1, 1'b0);
    push(2'b11, 16'h0042, 8'hB2, 1'b1, 1'b0);
    n = 0;
    while (!(harz_busy === 1'b1 && harz_req == HARZ80_NONE) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    check("t4_busy_phase_reached", 32'(harz_busy), 32'd1);
    check("t4_queue_not_empty", 32'(idle), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_req_none", 32'(harz_req), 32'(HARZ80_NONE));
    check("t4_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t4_idle", 32'(idle), 32'd1);
    iss_q.delete();
    rsp_q.delete();
    rst      = 1'b0;
    busy_len = 3;
    iss0     = issue_seen;
    repeat (40) @(posedge clk);
    #1;
    check("t4_no_issue_after_reset", 32'(issue_seen - iss0), 32'd0);
    check("t4_no_response", 32'(rsp_seen - rsp0), 32'd0);
    check("t4_idle_after", 32'(idle), 32'd1);

`ifdef HARZ_REQ_TIMEOUT_EN
    // 5: host never answers; response after 16 cycles, then normal service
    host_silent = 1'b1;
    push(2'b00, 16'h1234, 8'h00, 1'b1, 1'b1);
    wait_done(200);
    check("t5_timeout_latency", 32'(last_rsp_cyc - last_req_cyc), 32'd16);
    host_silent = 1'b0;
    rsp0 = rsp_seen;
    push(2'b01, 16'h2222, 8'h77, 1'b1, 1'b0);
    wait_done(200);
    check("t5_next_rsp_count", 32'(rsp_seen - rsp0), 32'd1);
`endif

    // 6: back-to-back mixed sequence
    rsp0 = rsp_seen;
    push(2'b00, 16'h0000, 8'h00, 1'b1, 1'b0);
    push(2'b11, 16'h007C, 8'h11, 1'b1, 1'b0);
    push(2'b00, 16'hFFFF, 8'h00, 1'b1, 1'b0);
    wait_done(300);
    check("t6_rsp_count", 32'(rsp_seen - rsp0), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
